// File: rtl/fir_pkg.sv
// Shared widths, the capture FSM state type and a signed-max helper
// for the FIR capture block.
package fir_pkg;

  localparam int OUT_SIZE  = 16;
  localparam int CAP_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } cap_state_e;

  localparam logic [OUT_SIZE-1:0] SAMPLE_MIN = {1'b1, {(OUT_SIZE-1){1'b0}}};

  function automatic logic [OUT_SIZE-1:0] smax(input logic [OUT_SIZE-1:0] a,
                                               input logic [OUT_SIZE-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/fir_capture_buf.sv
// Capture storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module fir_capture_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_capture.sv
// Captures DEPTH strobed FIR output samples after an optional level trigger,
// tracks their signed peak, then streams them out over a valid/ready port.
module fir_capture
  import fir_pkg::*;
#(
  parameter int DEPTH = CAP_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fir_en,
  input  logic [OUT_SIZE-1:0] out_wave,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig_en,
  input  logic [OUT_SIZE-1:0] trig_level,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [OUT_SIZE-1:0] rd_data,
  output logic                rd_last,
  output logic                busy,
  output logic                done,
  output logic [OUT_SIZE-1:0] peak
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  cap_state_e          state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OUT_SIZE-1:0] peak_q, peak_d;
  logic                done_q, done_d;

  logic                trig_hit;
  logic                xfer;
  logic                buf_we;
  logic [PTR_W-1:0]    buf_waddr;

  assign trig_hit = fir_en && (!trig_en || ($signed(out_wave) >= $signed(trig_level)));
  assign xfer     = rd_valid && rd_ready;

  // abort overrides everything else this cycle, including the buffer write
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    peak_d    = peak_q;
    done_d    = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = wr_ptr_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d  = ST_ARMED;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            peak_d   = SAMPLE_MIN;
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            buf_we    = 1'b1;
            buf_waddr = '0;
            wr_ptr_d  = PTR_W'(1);
            peak_d    = smax(peak_q, out_wave);
            state_d   = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (fir_en) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            peak_d   = smax(peak_q, out_wave);
            if (wr_ptr_q == LAST_PTR) begin
              state_d = ST_READOUT;
            end
          end
        end
        ST_READOUT: begin
          if (xfer) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_q == LAST_PTR) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      peak_q   <= SAMPLE_MIN;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      peak_q   <= peak_d;
      done_q   <= done_d;
    end
  end

  fir_capture_buf #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_SIZE)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (out_wave),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid = (state_q == ST_READOUT);
  assign rd_last  = rd_valid && (rd_ptr_q == LAST_PTR);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign peak     = peak_q;

endmodule

// File: tb/tb_fir_capture.sv
// Directed bench for fir_capture: stimulus pushes expected readout words into
// a queue, an independent monitor pops and compares on every transfer.
module tb_fir_capture;
  import fir_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                fir_en = 1'b0;
  logic [OUT_SIZE-1:0] out_wave = '0;
  logic                arm = 1'b0;
  logic                abort = 1'b0;
  logic                trig_en = 1'b0;
  logic [OUT_SIZE-1:0] trig_level = '0;
  logic                rd_valid;
  logic                rd_ready = 1'b1;
  logic [OUT_SIZE-1:0] rd_data;
  logic                rd_last;
  logic                busy;
  logic                done;
  logic [OUT_SIZE-1:0] peak;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int xfer_idx = 0;

  logic [OUT_SIZE:0] exp_q[$];

  fir_capture #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fir_en     (fir_en),
    .out_wave   (out_wave),
    .arm        (arm),
    .abort      (abort),
    .trig_en    (trig_en),
    .trig_level (trig_level),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .busy       (busy),
    .done       (done),
    .peak       (peak)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on transfers, stall stability, done pulse count
  logic              prev_stall = 1'b0;
  logic [OUT_SIZE:0] prev_word = '0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (prev_stall && rd_valid)
      check("stall_stable", {15'b0, rd_last, rd_data}, {15'b0, prev_word});
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got data 0x%0h, expected no transfer", rd_data);
      end else begin
        logic [OUT_SIZE:0] e;
        e = exp_q.pop_front();
        check("xfer_word", {15'b0, rd_last, rd_data}, {15'b0, e});
        $display("xfer %0d: data=%0d last=%0b", xfer_idx, $signed(rd_data), rd_last);
        xfer_idx++;
      end
    end
    prev_stall = rd_valid && !rd_ready;
    prev_word  = {rd_last, rd_data};
  end

  task automatic cyc(input logic en, input int w);
    fir_en   = en;
    out_wave = w[OUT_SIZE-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm    = 1'b1;
    fir_en = 1'b0;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic push_exp(input int v, input logic last);
    exp_q.push_back({last, v[OUT_SIZE-1:0]});
  endtask

  task automatic wait_run_done(input string name);
    int n;
    n = 0;
    fir_en = 1'b0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, expected idle and 0", name, busy, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check({name, "_done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_last", {31'b0, rd_last}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_peak", {16'b0, peak}, 32'h8000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // free-running ramp 1..8
    trig_en = 1'b0;
    for (int i = 1; i <= 8; i++) push_exp(i, i == 8);
    do_arm();
    check("t1_busy_armed", {31'b0, busy}, 32'd1);
    for (int i = 1; i <= 7; i++) cyc(1'b1, i);
    check("t1_valid_early", {31'b0, rd_valid}, 32'd0);
    cyc(1'b1, 8);
    check("t1_valid_latency", {31'b0, rd_valid}, 32'd1);
    exp_done++;
    wait_run_done("t1");
    check("t1_peak", {16'b0, peak}, 32'd8);

    // level trigger at 100
    trig_en    = 1'b1;
    trig_level = 16'd100;
    push_exp(100, 0); push_exp(3, 0); push_exp(7, 0); push_exp(-2, 0);
    push_exp(0, 0);   push_exp(1, 0); push_exp(2, 0); push_exp(55, 1);
    do_arm();
    cyc(1'b1, -5); cyc(1'b1, 50); cyc(1'b1, 99);
    check("t2_still_armed", {31'b0, busy}, 32'd1);
    cyc(1'b1, 100); cyc(1'b1, 3); cyc(1'b1, 7); cyc(1'b1, -2);
    cyc(1'b1, 0);   cyc(1'b1, 1); cyc(1'b1, 2);
    check("t2_valid_early", {31'b0, rd_valid}, 32'd0);
    cyc(1'b1, 55);
    check("t2_valid", {31'b0, rd_valid}, 32'd1);
    exp_done++;
    wait_run_done("t2");
    check("t2_peak", {16'b0, peak}, 32'd100);

    // alternating strobe during capture
    trig_en = 1'b0;
    for (int k = 0; k < 8; k++) push_exp(10 + k, k == 7);
    do_arm();
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 10 + k);
      cyc(1'b0, 999);
    end
    check("t3_valid_early", {31'b0, rd_valid}, 32'd0);
    cyc(1'b1, 17);
    check("t3_valid", {31'b0, rd_valid}, 32'd1);
    exp_done++;
    wait_run_done("t3");
    check("t3_peak", {16'b0, peak}, 32'd17);

    // random ~30% ready, junk strobes during readout must be discarded
    rd_ready = 1'b0;
    for (int k = 0; k < 8; k++) push_exp(-20 + k, k == 7);
    do_arm();
    for (int k = 0; k < 8; k++) cyc(1'b1, -20 + k);
    for (int n = 0; n < 400; n++) begin
      if (!busy && exp_q.size() == 0) break;
      rd_ready = ($urandom_range(0, 9) < 3);
      cyc(1'b1, 16'h7FFF);
    end
    rd_ready = 1'b1;
    exp_done++;
    wait_run_done("t4");
    check("t4_peak", {16'b0, peak}, 32'h0000FFF3);

    // abort mid-capture, then re-arm
    do_arm();
    for (int k = 0; k < 4; k++) cyc(1'b1, 30 + k);
    abort = 1'b1;
    cyc(1'b1, 34);
    abort = 1'b0;
    check("t5_abort_busy", {31'b0, busy}, 32'd0);
    check("t5_abort_valid", {31'b0, rd_valid}, 32'd0);
    repeat (3) cyc(1'b0, 0);
    check("t5_no_done", done_cnt, exp_done);
    check("t5_peak_hold", {16'b0, peak}, 32'd33);
    arm   = 1'b1;
    abort = 1'b1;
    cyc(1'b0, 0);
    arm   = 1'b0;
    abort = 1'b0;
    check("t5_arm_abort_idle", {31'b0, busy}, 32'd0);
    for (int k = 0; k < 8; k++) push_exp(40 + k, k == 7);
    do_arm();
    for (int k = 0; k < 8; k++) cyc(1'b1, 40 + k);
    exp_done++;
    wait_run_done("t5");
    check("t5_peak", {16'b0, peak}, 32'd47);

    // asynchronous reset in readout
    rd_ready = 1'b0;
    do_arm();
    for (int k = 0; k < 8; k++) cyc(1'b1, 60 + k);
    check("t6_in_readout", {31'b0, rd_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, rd_valid}, 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_last", {31'b0, rd_last}, 32'd0);
    check("t6_rst_peak", {16'b0, peak}, 32'h8000);
    #1;
    rst = 1'b0;
    do_arm();
    check("t6_rearm_busy", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    cyc(1'b0, 0);
    abort = 1'b0;
    check("t6_abort_busy", {31'b0, busy}, 32'd0);
    rd_ready = 1'b1;
    repeat (2) cyc(1'b0, 0);
    check("final_done_cnt", done_cnt, exp_done);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
